// File: rtl/key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// key_sched_ctrl
//
// Sequencing controller for the 128-bit-key DES round-key generator. It
// steers the PC-1/feedback mux and the shift-1/shift-2 mux of the C/D
// half-key register and gates the register clock enable. Each round key is
// offered to the Feistel datapath with a valid/ready handshake, so the
// datapath can stall the key schedule.
//
// Optional feature: KEY_SCHED_LATCH_EN
//   defined   : Key_hold is a register captured from Key_in on an accepted
//               Start, so Key_in may change once Start has been taken.
//   undefined : Key_hold passes Key_in straight through, and Key_in only has
//               to be stable in the Start cycle.
//
// Parameters
//   ROUNDS     number of round keys per Start (1..16)
//   SHIFT_MAP  bit r = 1 selects shift-2 for round r, 0 selects shift-1
//
// Ports
//   Clk               clock, rising edge
//   Reset             asynchronous reset, active low
//   Start             one-cycle request for a full key schedule
//   Abort             cancel the running schedule
//   Key_in            user key
//   Key_ready         round datapath accepts the presented round key
//   Key_hold          key driven to PC-1
//   Select_mux_pc     1 = load C/D from PC-1, 0 = feedback from shifters
//   Select_mux_shift  1 = shift-2, 0 = shift-1
//   Reg_en            clock enable of the C/D register (combinational)
//   Key_valid         round key at the PC-2 output is valid
//   Round             index of the presented round key
//   Busy              schedule in progress
//   Done              one-cycle pulse after the last key is accepted
//
// States
//   IDLE | waiting for Start, C/D mux points at PC-1
//   RUN  | presenting round key Round, advancing on each handshake
//   FIN  | last key accepted, Done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module key_sched_ctrl #(
  parameter int unsigned ROUNDS    = 16,
  parameter logic [15:0] SHIFT_MAP = 16'h7EFC
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Abort,
  input  logic [127:0] Key_in,
  input  logic         Key_ready,
  output logic [127:0] Key_hold,
  output logic         Select_mux_pc,
  output logic         Select_mux_shift,
  output logic         Reg_en,
  output logic         Key_valid,
  output logic [4:0]   Round,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_e     state_q;
  logic [4:0] round_q;
  logic       key_valid_q;
  logic       busy_q;
  logic       done_q;
  logic       sel_pc_q;

  logic start_acc;
  logic handshake;
  logic last_round;

  // Abort outranks both a Start in IDLE and a handshake in RUN.
  assign start_acc  = (state_q == IDLE) && Start && !Abort;
  assign handshake  = (state_q == RUN) && Key_ready && !Abort;
  assign last_round = (round_q == LAST_ROUND);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      round_q     <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sel_pc_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_acc) begin
            state_q     <= RUN;
            round_q     <= '0;
            key_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            sel_pc_q    <= 1'b0;
          end
        end
        RUN: begin
          if (Abort) begin
            state_q     <= IDLE;
            round_q     <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sel_pc_q    <= 1'b1;
          end else if (Key_ready) begin
            if (last_round) begin
              // Round is held through FIN so the last index stays visible.
              state_q     <= FIN;
              key_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              round_q <= round_q + 5'd1;
            end
          end
        end
        FIN: begin
          state_q     <= IDLE;
          round_q     <= '0;
          key_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          sel_pc_q    <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          round_q     <= '0;
          key_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          sel_pc_q    <= 1'b1;
        end
      endcase
    end
  end

  // The C/D register loads PC-1 on the accepted Start edge and takes the
  // shifted value on every completed handshake. Reset also masks it, since
  // Start can be high while the state register is held in IDLE.
  assign Reg_en = Reset && (start_acc || handshake);

  // Shift select only matters while a key is presented; outside RUN it is
  // parked at shift-1.
  assign Select_mux_shift = key_valid_q && SHIFT_MAP[round_q[3:0]];

  assign Select_mux_pc = sel_pc_q;
  assign Key_valid     = key_valid_q;
  assign Round         = round_q;
  assign Busy          = busy_q;
  assign Done          = done_q;

`ifdef KEY_SCHED_LATCH_EN
  logic [127:0] key_hold_q;
  logic [127:0] key_hold_d;

  assign key_hold_d = start_acc ? Key_in : key_hold_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      key_hold_q <= '0;
    end else begin
      key_hold_q <= key_hold_d;
    end
  end

  // During the accepted Start cycle the register has not captured yet, so
  // PC-1 is fed from Key_in directly for the load edge.
  assign Key_hold = Reset ? key_hold_d : '0;
`else
  assign Key_hold = Reset ? Key_in : '0;
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
module tb_key_sched_ctrl;

  localparam int R = 16;
  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] KEY_F = {128{1'b1}};

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         Abort;
  logic [127:0] Key_in;
  logic         Key_ready;
  logic [127:0] Key_hold;
  logic         Select_mux_pc;
  logic         Select_mux_shift;
  logic         Reg_en;
  logic         Key_valid;
  logic [4:0]   Round;
  logic         Busy;
  logic         Done;

  key_sched_ctrl dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Start            (Start),
    .Abort            (Abort),
    .Key_in           (Key_in),
    .Key_ready        (Key_ready),
    .Key_hold         (Key_hold),
    .Select_mux_pc    (Select_mux_pc),
    .Select_mux_shift (Select_mux_shift),
    .Reg_en           (Reg_en),
    .Key_valid        (Key_valid),
    .Round            (Round),
    .Busy             (Busy),
    .Done             (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec;
  int n_err;

  // Reference model: phase -1 = idle, 0..R-1 = presenting round key, R = done cycle.
  int           phase;
  logic [127:0] held_key;
  logic [127:0] gold_key;
  logic [55:0]  cd_q;
  int           sched [R];
  int           cum   [R];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (phase %0d)", tag, got, exp, phase);
    end
  endtask

  function automatic logic [55:0] pc1(input logic [127:0] k);
    return k[55:0] ^ k[111:56];
  endfunction

  function automatic logic [55:0] rot(input logic [55:0] v, input int n);
    logic [27:0] c;
    logic [27:0] d;
    c = v[55:28];
    d = v[27:0];
    for (int i = 0; i < (n % 28); i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {c, d};
  endfunction

  task automatic step(input logic st, input logic ab, input logic rd,
                      input logic rs, input logic [127:0] k);
    logic         idle, valid, fin, acc;
    logic         e_reg_en;
    logic [127:0] e_hold;
    int           e_round;
    logic [55:0]  shifted;
    logic [55:0]  cd_n;
    int           ph_n;
    @(negedge Clk);
    Start = st; Abort = ab; Key_ready = rd; Reset = rs; Key_in = k;
    #1;
    if (!rs) begin
      phase    = -1;
      held_key = '0;
    end
    idle  = (phase < 0);
    valid = (phase >= 0) && (phase < R);
    fin   = (phase == R);
    acc   = rs && idle && st && !ab;
    e_round  = valid ? phase : (fin ? R - 1 : 0);
    e_reg_en = acc || (rs && valid && rd && !ab);
`ifdef KEY_SCHED_LATCH_EN
    e_hold = !rs ? '0 : (acc ? k : held_key);
`else
    e_hold = rs ? k : '0;
`endif
    chk("key_valid", 128'(Key_valid), 128'(valid));
    chk("busy", 128'(Busy), 128'(!idle));
    chk("done", 128'(Done), 128'(fin));
    chk("round", 128'(Round), 128'(e_round));
    chk("sel_pc", 128'(Select_mux_pc), 128'(idle));
    chk("sel_shift", 128'(Select_mux_shift), 128'(valid && sched[valid ? phase : 0] == 2));
    chk("reg_en", 128'(Reg_en), 128'(e_reg_en));
    chk("key_hold", Key_hold, e_hold);

    // Generator datapath driven by the DUT controls.
    shifted = rot(cd_q, Select_mux_shift ? 2 : 1);
    if (valid)
      chk("round_key", 128'(shifted), 128'(rot(pc1(gold_key), cum[phase])));
    cd_n = Reg_en ? (Select_mux_pc ? pc1(Key_hold) : shifted) : cd_q;

    ph_n = phase;
    if (!rs)            ph_n = -1;
    else if (idle) begin
      if (acc) begin
        ph_n     = 0;
        gold_key = k;
        held_key = k;
      end
    end
    else if (ab)        ph_n = -1;
    else if (fin)       ph_n = -1;
    else if (rd)        ph_n = phase + 1;

    @(posedge Clk);
    phase = ph_n;
    cd_q  = cd_n;
  endtask

  initial begin
    int s;
    n_vec = 0; n_err = 0;
    phase = -1; held_key = '0; gold_key = '0; cd_q = '0;
    sched = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    s = 0;
    for (int i = 0; i < R; i++) begin
      s += sched[i];
      cum[i] = s;
    end
    Start = 0; Abort = 0; Key_ready = 0; Reset = 0; Key_in = '0;

    // Reset, with Start high to show it is masked.
    step(1, 0, 1, 0, KEY_A);
    step(0, 0, 0, 0, KEY_A);
    step(0, 0, 0, 1, KEY_A);

    // Full schedule, ready held high; Key_in changes the cycle after Start.
    step(1, 0, 1, 1, KEY_A);
    for (int i = 0; i < R + 2; i++) step(0, 0, 1, 1, KEY_F);

    // Stall for 3 cycles at round 7.
    step(1, 0, 1, 1, $urandom() ? KEY_A : KEY_F);
    for (int i = 0; i < 40 && phase != 7; i++) step(0, 0, 1, 1, KEY_F);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, KEY_F);
    for (int i = 0; i < 40 && phase != R; i++) step(0, 0, 1, 1, KEY_F);
    // Restart in the cycle right after Done.
    step(0, 0, 1, 1, KEY_F);
    step(1, 0, 1, 1, KEY_A);

    // Ignored Start at round 3, abort with handshake at round 10.
    for (int i = 0; i < 40 && phase != 3; i++) step(0, 0, 1, 1, KEY_A);
    step(1, 0, 1, 1, KEY_F);
    for (int i = 0; i < 40 && phase != 10; i++) step(0, 0, 1, 1, KEY_A);
    step(0, 1, 1, 1, KEY_A);
    step(0, 0, 1, 1, KEY_A);

    // Reset mid-schedule at round 5, then a fresh schedule.
    step(1, 0, 1, 1, KEY_F);
    for (int i = 0; i < 40 && phase != 5; i++) step(0, 0, 1, 1, KEY_A);
    step(0, 0, 1, 0, KEY_A);
    step(1, 0, 1, 1, KEY_A);
    for (int i = 0; i < R + 2; i++) step(0, 0, 1, 1, KEY_A);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic st, ab, rd, rs;
      st = (phase < 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 31) == 0);
      rd = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 99) != 0);
      step(st, ab, rd, rs, {$urandom(), $urandom(), $urandom(), $urandom()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
